can_intreg: RTL and testbench

Interrupt register stage of the CAN controller's CPU interface. It sits directly downstream of the interrupt FSM and consumes the one-cycle indication strobes (`activintreg` qualified by `irqsucrec` / `irqsuctra` / `irqstatus`). It holds the pending-interrupt and interrupt-enable bits and feeds them back to the FSM as `irqstd` / `ienable`. It also gives the host CPU a small register file for enable programming, write-1-to-clear acknowledge and registered readback.

---
 rtl/can_intreg.sv | 121 ++++++++++++
 tb/tb_can_intreg.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/can_intreg.sv
// CAN CPU-interface interrupt register stage: pending/enable bits fed back to the interrupt FSM,
// plus a small CPU register file. Optional overrun capture enabled by macro CAN_INTREG_OVERRUN_EN.
module can_intreg #(
  parameter int unsigned DW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          activintreg,
  input  logic          irqsucrec,
  input  logic          irqsuctra,
  input  logic          irqstatus,
  input  logic          sucfrec,
  input  logic          sucftra,
  input  logic          irqsig,
  input  logic          cpu_wr,
  input  logic          cpu_rd,
  input  logic [1:0]    cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  output logic [2:0]    irqstd,
  output logic [2:0]    ienable
);

  localparam int unsigned NIRQ = 3;
  localparam logic [1:0] ADDR_STATUS  = 2'd0;
  localparam logic [1:0] ADDR_ENABLE  = 2'd1;
  localparam logic [1:0] ADDR_OVERRUN = 2'd2;

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [NIRQ-1:0] irqstd_q, irqstd_d;
  logic [NIRQ-1:0] ienable_q, ienable_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [NIRQ-1:0] set_vec;
  logic [NIRQ-1:0] stat_clr;
  logic [DW-1:0]   rd_mux;

  // Upper write-data bits have no storage behind them.
  logic unused_wdata;
  assign unused_wdata = ^cpu_wdata[DW-1:NIRQ];

`ifdef CAN_INTREG_OVERRUN_EN
  logic [NIRQ-1:0] ovr_q, ovr_d;
  logic [NIRQ-1:0] ovr_set;
  logic [NIRQ-1:0] ovr_clr;
`else
  logic unused_raw;
  assign unused_raw = sucfrec ^ sucftra ^ irqsig;
`endif

  always_comb begin
    state_d   = state_q;
    irqstd_d  = irqstd_q;
    ienable_d = ienable_q;
    rdata_d   = rdata_q;
    rd_mux    = '0;
    set_vec   = activintreg ? {irqstatus, irqsuctra, irqsucrec} : '0;
    stat_clr  = (cpu_wr && cpu_addr == ADDR_STATUS) ? cpu_wdata[NIRQ-1:0] : '0;

    // Set wins over a same-cycle write-1-to-clear so no indication is lost.
    irqstd_d = (irqstd_q & ~stat_clr) | set_vec;

    if (cpu_wr && cpu_addr == ADDR_ENABLE) begin
      ienable_d = cpu_wdata[NIRQ-1:0];
    end

`ifdef CAN_INTREG_OVERRUN_EN
    ovr_d   = ovr_q;
    ovr_set = {irqsig, sucftra, sucfrec} & irqstd_q & ienable_q;
    ovr_clr = (cpu_wr && cpu_addr == ADDR_OVERRUN) ? cpu_wdata[NIRQ-1:0] : '0;
    ovr_d   = (ovr_q & ~ovr_clr) | ovr_set;
`endif

    case (cpu_addr)
      ADDR_STATUS:  rd_mux = DW'(irqstd_q);
      ADDR_ENABLE:  rd_mux = DW'(ienable_q);
`ifdef CAN_INTREG_OVERRUN_EN
      ADDR_OVERRUN: rd_mux = DW'(ovr_q);
`endif
      default:      rd_mux = '0;
    endcase

    // Reads capture pre-edge register values; a read in RESP re-arms RESP.
    case (state_q)
      IDLE: if (cpu_rd) state_d = RESP;
      RESP: if (!cpu_rd) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (cpu_rd) begin
      rdata_d = rd_mux;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      irqstd_q  <= '0;
      ienable_q <= '0;
      rdata_q   <= '0;
`ifdef CAN_INTREG_OVERRUN_EN
      ovr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      irqstd_q  <= irqstd_d;
      ienable_q <= ienable_d;
      rdata_q   <= rdata_d;
`ifdef CAN_INTREG_OVERRUN_EN
      ovr_q     <= ovr_d;
`endif
    end
  end

  assign irqstd     = irqstd_q;
  assign ienable    = ienable_q;
  assign cpu_rdata  = rdata_q;
  assign cpu_rvalid = (state_q == RESP);

endmodule

// File: tb/tb_can_intreg.sv
// Scoreboard bench for can_intreg: reads push expected data/cycle, a negedge monitor pops on cpu_rvalid.
module tb_can_intreg;

  localparam int unsigned DW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          activintreg = 1'b0, irqsucrec = 1'b0, irqsuctra = 1'b0, irqstatus = 1'b0;
  logic          sucfrec = 1'b0, sucftra = 1'b0, irqsig = 1'b0;
  logic          cpu_wr = 1'b0, cpu_rd = 1'b0;
  logic [1:0]    cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;
  logic [2:0]    irqstd, ienable;

  can_intreg #(.DW(DW)) dut (
    .clock(clock), .reset(reset),
    .activintreg(activintreg), .irqsucrec(irqsucrec), .irqsuctra(irqsuctra), .irqstatus(irqstatus),
    .sucfrec(sucfrec), .sucftra(sucftra), .irqsig(irqsig),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .irqstd(irqstd), .ienable(ienable)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
    string         name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rvalid pulse must match the oldest outstanding read in data and timing.
  always @(negedge clock) begin
    if (cpu_rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", 32'(cpu_rvalid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_data"}, 32'(cpu_rdata), 32'(e.data));
        chk({e.name, "_cycle"}, 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_wr(input logic [1:0] a, input logic [DW-1:0] d);
    cpu_wr = 1'b1; cpu_addr = a; cpu_wdata = d;
    tick();
    cpu_wr = 1'b0; cpu_wdata = '0;
  endtask

  task automatic do_rd(input logic [1:0] a, input logic [DW-1:0] exp, input string name);
    exp_t e;
    cpu_rd = 1'b1; cpu_addr = a;
    e.data = exp; e.due = cyc + 1; e.name = name;
    sb.push_back(e);
    tick();
    cpu_rd = 1'b0;
  endtask

  task automatic strobe(input logic rec, input logic tra, input logic stat);
    activintreg = 1'b1; irqsucrec = rec; irqsuctra = tra; irqstatus = stat;
    tick();
    activintreg = 1'b0; irqsucrec = 1'b0; irqsuctra = 1'b0; irqstatus = 1'b0;
  endtask

  logic [DW-1:0] ovr_exp;

  initial begin
`ifdef CAN_INTREG_OVERRUN_EN
    ovr_exp = 8'h02;
`else
    ovr_exp = 8'h00;
`endif
    reset = 1'b0;
    tick(); tick();
    chk("rst_irqstd", 32'(irqstd), 32'd0);
    chk("rst_ienable", 32'(ienable), 32'd0);
    chk("rst_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst_rdata", 32'(cpu_rdata), 32'd0);
    reset = 1'b1;
    tick();

    // Back-to-back reads of all four addresses after reset.
    for (int a = 0; a < 4; a++) do_rd(2'(a), 8'h00, $sformatf("rst_read_a%0d", a));
    tick(); tick();

    do_wr(2'd1, 8'h07);
    chk("enable_07", 32'(ienable), 32'h7);
    strobe(1'b0, 1'b1, 1'b0);
    chk("set_tra", 32'(irqstd), 32'h2);
    do_rd(2'd0, 8'h02, "read_status_tra");

    // Qualifier without activintreg is ignored.
    irqsucrec = 1'b1; irqstatus = 1'b1;
    tick();
    irqsucrec = 1'b0; irqstatus = 1'b0;
    chk("qual_no_strobe", 32'(irqstd), 32'h2);

    strobe(1'b1, 1'b1, 1'b1);
    chk("set_all", 32'(irqstd), 32'h7);
    do_wr(2'd0, 8'h05);
    chk("w1c_05", 32'(irqstd), 32'h2);
    do_wr(2'd1, 8'h00);
    chk("disable_keeps_pending", 32'(irqstd), 32'h2);
    chk("enable_00", 32'(ienable), 32'h0);
    do_rd(2'd1, 8'h00, "read_enable_00");

    // Set-over-clear on bit 0.
    strobe(1'b1, 1'b0, 1'b0);
    chk("set_rec", 32'(irqstd), 32'h3);
    activintreg = 1'b1; irqsucrec = 1'b1;
    do_wr(2'd0, 8'h01);
    activintreg = 1'b0; irqsucrec = 1'b0;
    chk("set_wins_clear", 32'(irqstd), 32'h3);
    do_wr(2'd0, 8'h02);
    chk("w1c_02", 32'(irqstd), 32'h1);

    // Same-cycle read/write returns pre-edge value.
    do_wr(2'd1, 8'h07);
    cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 2'd1; cpu_wdata = 8'h03;
    begin
      exp_t e;
      e.data = 8'h07; e.due = cyc + 1; e.name = "rw_same_cycle";
      sb.push_back(e);
    end
    tick();
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_wdata = '0;
    do_rd(2'd1, 8'h03, "read_enable_03");
    do_rd(2'd3, 8'h00, "read_addr3");

    // Overrun: only bit 1 is pending and enabled among the pulsed events.
    do_wr(2'd1, 8'h07);
    strobe(1'b0, 1'b1, 1'b0);
    chk("pre_ovr_irqstd", 32'(irqstd), 32'h3);
    sucftra = 1'b1; irqsig = 1'b1;
    tick();
    sucftra = 1'b0; irqsig = 1'b0;
    do_rd(2'd2, ovr_exp, "read_ovr");
    do_wr(2'd2, 8'h02);
    do_rd(2'd2, 8'h00, "read_ovr_cleared");

    // Reset on the same edge as a read aborts the response.
    tick(); tick();
    cpu_rd = 1'b1; cpu_addr = 2'd0; reset = 1'b0;
    tick();
    cpu_rd = 1'b0;
    chk("rst_mid_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst_mid_irqstd", 32'(irqstd), 32'd0);
    chk("rst_mid_ienable", 32'(ienable), 32'd0);
    reset = 1'b1;
    tick(); tick();

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) chk("scoreboard_drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
